uart_rx_cfg: RTL
================

Name: uart_rx_cfg

Overview:
Parametrised UART receiver, the next generation of our oversampled RX. It adds runtime-configurable oversampling, parity and stop bits, a 2-flop input synchroniser and false-start rejection. Each bit is decided by a 3-sample mid-bit majority vote, and the block reports parity, framing, break and overrun conditions. A valid/ready output handshake feeds a downstream FIFO or register file.

Parameters:
DATA_BITS, 8, payload bits per frame, legal range 5..9
LSB_FIRST, 1, 1: first received data bit lands in dout[0]; 0: first received bit lands in dout[DATA_BITS-1]

Ports:
s_tick  input  1  oversampling clock; every rising edge is one sample tick
reset  input  1  asynchronous, active-high reset
rx  input  1  serial line, asynchronous, idle high
oversampling  input  5  ticks per bit, legal 4..31
parity_mode  input  2  00 none, 01 even, 10 odd, 11 none
stop_bits  input  1  0: one stop bit, 1: two stop bits
dout  output  DATA_BITS  received payload
dout_valid  output  1  dout holds an unconsumed frame
dout_ready  input  1  consumer accepts dout while dout_valid=1
rx_done  output  1  one-tick pulse on frame completion
parity_err  output  1  parity mismatch on the last frame
frame_err  output  1  a stop bit sampled low on the last frame
break_det  output  1  last frame was all-zero including parity and stop
overrun  output  1  one-tick pulse when a completed frame overwrote an unconsumed one

Behaviour:
- Reset (async): state IDLE, counters 0. Both synchroniser flops reset to 1. dout=0; dout_valid, rx_done, parity_err, frame_err, break_det and overrun all 0.
- All sampling uses rx_s, the second synchroniser stage. This adds 2 ticks of latency.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: when rx_s=0, latch oversampling (OS), parity_mode and stop_bits, clear the counter, go to START. If the oversampling input is below 4, stay in IDLE and ignore rx.
- Bit window: the counter runs 0..OS-1. Sample ticks are counter = OS/2-1, OS/2 and OS/2+1, where OS/2 uses floor. The bit value is the majority of those 3 samples.
- START: at counter=OS/2, if rx_s=1, abort to IDLE (false start; no flags, no outputs). Otherwise go to DATA at counter=OS-1.
- DATA: one window per bit, DATA_BITS windows in total. Each decided bit is shifted into the assembly register according to LSB_FIRST. After the last bit, go to PARITY if parity is enabled, otherwise to STOP.
- PARITY: one window. Even parity requires the XOR of the data bits and the parity bit to be 0; odd parity requires it to be 1. A mismatch sets an internal parity error.
- STOP: one or two windows.
  - Any stop bit decided 0 sets an internal frame error.
  - The frame completes at counter=OS/2+1 of the final stop bit, after its majority is decided. The block does not wait for the window end, so it can resync to back-to-back frames.
  - On completion, go to IDLE. IDLE only re-arms once rx_s has returned high after a low stop bit, so a stuck-low line does not retrigger.
- Completion tick, all updated together:
  - dout <= assembled data.
  - dout_valid <= 1.
  - rx_done pulses for one tick.
  - parity_err and frame_err take the internal values. They hold until the next completion.
  - break_det=1 iff all data bits, the parity bit (if enabled) and every stop bit were 0. It implies frame_err=1.
- Handshake:
  - dout_valid clears on a tick where dout_valid=1 and dout_ready=1.
  - Completion with dout_valid=1 and dout_ready=0: dout is overwritten, dout_valid stays 1, overrun pulses.
  - Completion on the same tick as dout_ready=1: the new data loads, dout_valid stays 1, no overrun.
- Config inputs are ignored mid-frame; only the values latched in IDLE apply.
- Reset mid-frame discards the partial frame; no rx_done is produced.

Decomposition:
- Package uart_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - parity mode constants PAR_NONE, PAR_EVEN, PAR_ODD;
  - OS_MIN=4.
- Sub-module uart_rx_sampler: 2-flop synchroniser plus the 3-sample majority voter. Inputs are the counter and the latched OS; outputs are rx_s and bit_val.
- The FSM, shift register, error logic and handshake stay in uart_rx_cfg.

Test Plan:
1. OS=16, no parity, 1 stop, send 0xA5 LSB-first -> dout=0xA5, rx_done for 1 tick, dout_valid=1, all error flags 0.
2. OS=16, even parity, send 0x03 with parity bit 1 -> parity_err=1. Resend with parity bit 0 -> parity_err=0.
3. OS=8, 2 stop bits, second stop bit driven low -> frame_err=1, dout still loaded. Then send a line held low for a whole frame -> break_det=1, frame_err=1, dout=0x00.
4. 1-tick-wide glitch low on an idle line at OS=16 -> no state leaves START for DATA, rx_done stays 0.
5. Two back-to-back frames 0x11 then 0x22 with dout_ready=0 -> overrun pulses on the second, dout=0x22. Repeat with dout_ready=1 on the completion tick -> no overrun.
6. Assert reset during DATA of frame 0x5A, release, send 0x3C -> only 0x3C is reported, with dout_valid=1 and no errors.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // Smallest oversampling ratio that still leaves room for three mid-bit samples.
    localparam logic [4:0] OS_MIN = 5'd4;

    function automatic logic par_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Input synchroniser and 3-sample mid-bit majority voter.
module uart_rx_sampler
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic [4:0] cnt,
    input  logic [4:0] os,
    output logic       rx_s,
    output logic       bit_val
);

    logic       sync1_q, sync2_q;
    logic       s0_q, s0_d;
    logic       s1_q, s1_d;
    logic [4:0] half;

    assign half = 5'(os >> 1);

    // Two-flop synchroniser; idles high so reset does not look like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
        end
    end

    // Capture the first two of the three mid-bit samples.
    always_comb begin
        s0_d = s0_q;
        s1_d = s1_q;
        if (cnt == half - 5'd1) s0_d = sync2_q;
        if (cnt == half)        s1_d = sync2_q;
    end

    // Sample holding registers; their content only matters inside a bit window.
    always_ff @(posedge clk) begin
        s0_q <= s0_d;
        s1_q <= s1_d;
    end

    assign rx_s = sync2_q;
    // Valid on the third sample tick (cnt == half+1), using the live sample.
    assign bit_val = (s0_q & s1_q) | (s0_q & sync2_q) | (s1_q & sync2_q);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: FSM, payload assembly, error flags and output handshake.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                 s_tick,
    input  logic                 reset,
    input  logic                 rx,
    input  logic [4:0]           oversampling,
    input  logic [1:0]           parity_mode,
    input  logic                 stop_bits,
    output logic [DATA_BITS-1:0] dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 rx_done,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 overrun
);

    localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

    state_t               state_q, state_d;
    logic [4:0]           cnt_q, cnt_d;
    logic [4:0]           os_q, os_d;
    logic [1:0]           par_q, par_d;
    logic                 stop2_q, stop2_d;
    logic [3:0]           bit_idx_q, bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_acc_q, par_acc_d;
    logic                 pe_acc_q, pe_acc_d;
    logic                 fe_acc_q, fe_acc_d;
    logic                 zero_acc_q, zero_acc_d;
    logic                 armed_q, armed_d;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic                 dout_valid_q, dout_valid_d;
    logic                 rx_done_q, rx_done_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 break_det_q, break_det_d;
    logic                 overrun_q, overrun_d;

    logic       rx_s, bit_val;
    logic [4:0] half;
    logic       at_last, at_dec;
    logic       complete, fe_fin, zero_fin;

    uart_rx_sampler u_sampler (
        .clk     (s_tick),
        .rst     (reset),
        .rx      (rx),
        .cnt     (cnt_q),
        .os      (os_q),
        .rx_s    (rx_s),
        .bit_val (bit_val)
    );

    assign half    = 5'(os_q >> 1);
    assign at_last = (cnt_q == os_q - 5'd1);
    assign at_dec  = (cnt_q == half + 5'd1);

    // Next-state logic for the frame FSM, assembly/error accumulators and handshake.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        os_d         = os_q;
        par_d        = par_q;
        stop2_d      = stop2_q;
        bit_idx_d    = bit_idx_q;
        stop_idx_d   = stop_idx_q;
        shreg_d      = shreg_q;
        par_acc_d    = par_acc_q;
        pe_acc_d     = pe_acc_q;
        fe_acc_d     = fe_acc_q;
        zero_acc_d   = zero_acc_q;
        armed_d      = armed_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        rx_done_d    = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        break_det_d  = break_det_q;
        overrun_d    = 1'b0;
        complete     = 1'b0;
        fe_fin       = fe_acc_q | ~bit_val;
        zero_fin     = zero_acc_q & ~bit_val;

        case (state_q)
            IDLE: begin
                cnt_d = 5'd0;
                if (!armed_q) begin
                    // Wait for the line to go high again after a low stop bit.
                    if (rx_s) armed_d = 1'b1;
                end else if (!rx_s && oversampling >= OS_MIN) begin
                    state_d    = START;
                    os_d       = oversampling;
                    par_d      = parity_mode;
                    stop2_d    = stop_bits;
                    bit_idx_d  = 4'd0;
                    stop_idx_d = 1'b0;
                    par_acc_d  = 1'b0;
                    pe_acc_d   = 1'b0;
                    fe_acc_d   = 1'b0;
                    zero_acc_d = 1'b1;
                end
            end
            START: begin
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == half && rx_s) begin
                    state_d = IDLE;
                    cnt_d   = 5'd0;
                end else if (at_last) begin
                    state_d = DATA;
                    cnt_d   = 5'd0;
                end
            end
            DATA: begin
                cnt_d = cnt_q + 5'd1;
                if (at_dec) begin
                    if (LSB_FIRST) shreg_d = {bit_val, shreg_q[DATA_BITS-1:1]};
                    else           shreg_d = {shreg_q[DATA_BITS-2:0], bit_val};
                    par_acc_d  = par_acc_q ^ bit_val;
                    zero_acc_d = zero_fin;
                end
                if (at_last) begin
                    cnt_d = 5'd0;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d    = par_enabled(par_q) ? PARITY : STOP;
                        stop_idx_d = 1'b0;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
            end
            PARITY: begin
                cnt_d = cnt_q + 5'd1;
                if (at_dec) begin
                    pe_acc_d   = (par_acc_q ^ bit_val) != (par_q == PAR_ODD);
                    zero_acc_d = zero_fin;
                end
                if (at_last) begin
                    state_d    = STOP;
                    cnt_d      = 5'd0;
                    stop_idx_d = 1'b0;
                end
            end
            STOP: begin
                cnt_d = cnt_q + 5'd1;
                if (at_dec && (stop_idx_q == stop2_q)) begin
                    // Finish mid-window so a following start edge is not missed.
                    complete = 1'b1;
                    state_d  = IDLE;
                    cnt_d    = 5'd0;
                    armed_d  = bit_val;
                end else begin
                    if (at_dec) begin
                        fe_acc_d   = fe_fin;
                        zero_acc_d = zero_fin;
                    end
                    if (at_last) begin
                        stop_idx_d = 1'b1;
                        cnt_d      = 5'd0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 5'd0;
            end
        endcase

        if (dout_valid_q && dout_ready) dout_valid_d = 1'b0;

        if (complete) begin
            dout_d       = shreg_q;
            dout_valid_d = 1'b1;
            rx_done_d    = 1'b1;
            parity_err_d = pe_acc_q;
            frame_err_d  = fe_fin;
            break_det_d  = zero_fin;
            overrun_d    = dout_valid_q && !dout_ready;
        end
    end

    // State and output registers; reset discards any partial frame.
    always_ff @(posedge s_tick or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 5'd0;
            os_q         <= 5'd0;
            par_q        <= PAR_NONE;
            stop2_q      <= 1'b0;
            bit_idx_q    <= 4'd0;
            stop_idx_q   <= 1'b0;
            shreg_q      <= '0;
            par_acc_q    <= 1'b0;
            pe_acc_q     <= 1'b0;
            fe_acc_q     <= 1'b0;
            zero_acc_q   <= 1'b0;
            armed_q      <= 1'b1;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            rx_done_q    <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            break_det_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            os_q         <= os_d;
            par_q        <= par_d;
            stop2_q      <= stop2_d;
            bit_idx_q    <= bit_idx_d;
            stop_idx_q   <= stop_idx_d;
            shreg_q      <= shreg_d;
            par_acc_q    <= par_acc_d;
            pe_acc_q     <= pe_acc_d;
            fe_acc_q     <= fe_acc_d;
            zero_acc_q   <= zero_acc_d;
            armed_q      <= armed_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            rx_done_q    <= rx_done_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            break_det_q  <= break_det_d;
            overrun_q    <= overrun_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign rx_done    = rx_done_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign break_det  = break_det_q;
    assign overrun    = overrun_q;

endmodule
